// File: rtl/bitstream_prefetch.sv
// Bitstream prefetch buffer: host words fill a circular RAM, the decoder reads by absolute
// stream address, and space is released behind the highest read address minus RETAIN.
module bitstream_prefetch #(
    parameter int AW     = 9,
    parameter int RETAIN = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [15:0]   host_data,
    input  logic          BitStream_ram_ren,
    input  logic [16:0]   BitStream_ram_addr,
    output logic [15:0]   BitStream_buffer_input,
    output logic          rd_miss,
    output logic          underrun,
    output logic [AW:0]   fill_level
);

    localparam int          FW       = AW + 1;
    localparam int          DEPTH    = 1 << AW;
    localparam logic [FW-1:0] DEPTH_C  = FW'(DEPTH);
    localparam logic [16:0] RETAIN_C = 17'(RETAIN);

    // True when a is strictly ahead of b within half the 17-bit address space.
    function automatic logic ahead_f(input logic [16:0] a, input logic [16:0] b);
        logic [16:0] d;
        d = a - b;
        return (d != 17'd0) && !d[16];
    endfunction

    logic [15:0]   mem_r [DEPTH];
    logic [16:0]   wr_ptr_r, rd_base_r, rd_max_r;
    logic          host_ready_r, rd_miss_r, underrun_r;
    logic [15:0]   rdata_r;
    logic [FW-1:0] fill_r;

    logic          wr_fire_s, rd_hit_s;
    logic [16:0]   fill_cur_s, rd_off_s, rel_s;
    logic [16:0]   wr_ptr_nxt_s, rd_base_nxt_s, rd_max_nxt_s;
    logic [FW-1:0] fill_nxt_s;
    logic          ready_nxt_s, underrun_nxt_s;

    // Hit test, pointer release and next-state computation.
    always_comb begin
        wr_fire_s     = host_valid && host_ready_r && !flush;
        fill_cur_s    = wr_ptr_r - rd_base_r;
        rd_off_s      = BitStream_ram_addr - rd_base_r;
        rd_hit_s      = BitStream_ram_ren && !flush && (rd_off_s < fill_cur_s);
        rel_s         = BitStream_ram_addr - RETAIN_C;
        wr_ptr_nxt_s  = wr_ptr_r;
        rd_base_nxt_s = rd_base_r;
        rd_max_nxt_s  = rd_max_r;
        underrun_nxt_s = underrun_r;
        if (flush) begin
            wr_ptr_nxt_s   = 17'd0;
            rd_base_nxt_s  = 17'd0;
            rd_max_nxt_s   = 17'd0;
            underrun_nxt_s = 1'b0;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + {16'd0, wr_fire_s};
            if (rd_hit_s) begin
                if (ahead_f(BitStream_ram_addr, rd_max_r)) begin
                    rd_max_nxt_s = BitStream_ram_addr;
                end else begin
                    rd_max_nxt_s = rd_max_r;
                end
                if (ahead_f(rel_s, rd_base_r) && !ahead_f(rel_s, wr_ptr_r)) begin
                    rd_base_nxt_s = rel_s;
                end else begin
                    rd_base_nxt_s = rd_base_r;
                end
            end else if (BitStream_ram_ren) begin
                underrun_nxt_s = 1'b1;
            end else begin
                underrun_nxt_s = underrun_r;
            end
        end
        // Level never exceeds DEPTH, so truncating to AW+1 bits is exact.
        fill_nxt_s  = FW'(wr_ptr_nxt_s - rd_base_nxt_s);
        ready_nxt_s = (fill_nxt_s < DEPTH_C);
    end

    // Buffer RAM write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= host_data;
        end
    end

    // Pointer, flag and read-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= 17'd0;
            rd_base_r    <= 17'd0;
            rd_max_r     <= 17'd0;
            host_ready_r <= 1'b0;
            rd_miss_r    <= 1'b0;
            underrun_r   <= 1'b0;
            rdata_r      <= 16'h0000;
            fill_r       <= '0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_base_r    <= rd_base_nxt_s;
            rd_max_r     <= rd_max_nxt_s;
            host_ready_r <= ready_nxt_s;
            rd_miss_r    <= BitStream_ram_ren && !rd_hit_s;
            underrun_r   <= underrun_nxt_s;
            fill_r       <= fill_nxt_s;
            if (BitStream_ram_ren) begin
                rdata_r <= rd_hit_s ? mem_r[BitStream_ram_addr[AW-1:0]] : 16'h0000;
            end
        end
    end

    assign host_ready             = host_ready_r;
    assign BitStream_buffer_input = rdata_r;
    assign rd_miss                = rd_miss_r;
    assign underrun               = underrun_r;
    assign fill_level             = fill_r;

endmodule

// File: doc/bitstream_prefetch.md
Name: bitstream_prefetch

Overview:
- Bitstream source stage that sits directly upstream of the NOVA decoder.
- Accepts 16-bit bitstream words pushed by a host/DMA through a valid/ready handshake and stores them in an internal circular buffer.
- Serves the decoder's random-address reads (BitStream_ram_ren / BitStream_ram_addr) with one-cycle registered data on BitStream_buffer_input.
- Releases buffer space as the decoder's read pointer advances, keeping a lookback window of RETAIN words.

Parameters:
- AW, 9, log2 of buffer depth; DEPTH = 2^AW words (512).
- RETAIN, 64, words behind the highest address read that stay readable; must be < DEPTH.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; clears all pointers and flags. Takes priority over all other activity that cycle.
- host_valid  input  1  host word valid.
- host_ready  output  1  buffer can accept a word.
- host_data  input  16  bitstream word, in stream order.
- BitStream_ram_ren  input  1  decoder read enable, active-high.
- BitStream_ram_addr  input  17  decoder word address (absolute stream word index).
- BitStream_buffer_input  output  16  read data.
- rd_miss  output  1  one-cycle pulse aligned with read data; the requested word was not resident.
- underrun  output  1  sticky; set on any rd_miss.
- fill_level  output  AW+1  words held, i.e. wr_ptr - rd_base.

Behaviour:
- State registers:
  - wr_ptr (17b): address of the next word to be written.
  - rd_base (17b): oldest retained address.
  - rd_max (17b): highest address read with a hit.
- All address arithmetic is modulo 2^17.
- "a ahead of b" means (a-b) mod 2^17 is in 1..2^16-1.
- Reset values: all pointers 0, host_ready 0 while reset is asserted, BitStream_buffer_input 0, rd_miss 0, underrun 0, fill_level 0.
- host_ready is registered; it equals (fill_level < DEPTH) using the post-update pointers. It is 1 in the first cycle after reset deasserts.
- Write:
  - When host_valid && host_ready, store host_data at mem[wr_ptr[AW-1:0]] and increment wr_ptr.
  - host_data must be held until accepted. No write occurs when host_ready=0.
- Read:
  - Sampled when BitStream_ram_ren=1.
  - Hit test uses the pre-write wr_ptr: hit if (addr - rd_base) < (wr_ptr - rd_base).
  - Latency is 1 cycle. On a hit, BitStream_buffer_input = mem[addr[AW-1:0]] and rd_miss=0.
  - On a miss, BitStream_buffer_input = 16'h0000, rd_miss=1, and underrun is set.
  - With ren=0, BitStream_buffer_input holds its last value and rd_miss=0.
- Same-cycle write and read of address wr_ptr: reported as a miss. The word is readable from the next cycle.
- Release (on hits only):
  - If addr is ahead of rd_max, then rd_max <= addr.
  - If (addr - RETAIN) is ahead of rd_base and not ahead of wr_ptr, then rd_base <= addr - RETAIN.
  - rd_base never moves backwards.
  - A hit at an address below RETAIN releases nothing.
  - Misses never update rd_max or rd_base.
- Full: fill_level = DEPTH drops host_ready the next cycle. A same-cycle release and write may keep the level at DEPTH.
- Wrap: stream addresses wrap from 17'h1FFFF to 0 with no special handling. Buffer slot = low AW bits.
- Flush:
  - Next cycle: wr_ptr = rd_base = rd_max = 0, underrun = 0, fill_level = 0, host_ready = 1.
  - A host word presented in the flush cycle is dropped and not acknowledged.
  - A read in the flush cycle returns as a miss but does not set underrun.
- Reset mid-operation: everything returns to reset values immediately. Buffer RAM contents are don't-care.

Test Plan:
- Reset, then push words 0x0000..0x01FF (512 words) -> host_ready=1 throughout and falls to 0 the cycle after the 512th accept; fill_level=512.
- After the fill, read addr 5 -> next cycle BitStream_buffer_input=0x0005, rd_miss=0; fill_level stays 512 (5 < RETAIN).
- Read addr 100 -> data 0x0064; rd_base becomes 36, fill_level=476, host_ready returns to 1 the next cycle.
- Read addr 600 (not yet written) -> BitStream_buffer_input=0, rd_miss pulses 1 cycle, underrun=1 and stays set; rd_base is unchanged.
- Stream 131,100 words with reads trailing the writer by 16 -> no misses across the 17'h1FFFF->0 wrap; data at addr 3 after the wrap equals word 131075.
- flush asserted with host_valid=1 and ren=1 -> that word is not accepted, the read reports a miss but underrun is not set, and all counters are 0 the next cycle.
